// File: rtl/eth_vlg_ram_arb_if.sv
// Requester and RAM-side signal bundle for eth_vlg_ram_arb.
// The arbiter connects through the slave modport; requesters and the RAM model use master.
interface eth_vlg_ram_arb_if #(
    parameter int N  = 2,
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N-1:0]    w;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   q;
    logic [N-1:0]    qv;
    logic            ram_w;
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_d;
    logic [DW-1:0]   ram_q;

    modport master (
        output req, lock, w, a, d, ram_q,
        input  gnt, q, qv, ram_w, ram_a, ram_d
    );

    modport slave (
        input  req, lock, w, a, d, ram_q,
        output gnt, q, qv, ram_w, ram_a, ram_d
    );
endinterface

// File: rtl/eth_vlg_ram_arb.sv
// Round-robin arbiter sharing one single-port RAM between N requesters, with burst lock.
// Optional macro ETH_VLG_RAM_ARB_STATS_EN adds per-requester saturating stall counters.
module eth_vlg_ram_arb #(
    parameter int N  = 2,
    parameter int AW = 16,
    parameter int DW = 16
) (
    input logic               clk,
    input logic               rst_n,
    eth_vlg_ram_arb_if.slave  bus
`ifdef ETH_VLG_RAM_ARB_STATS_EN
    ,
    output logic [N*16-1:0]   stall_cnt_o
`endif
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   lockOwner_q, lockOwner_d;
    logic            ram_w_q, ram_w_d;
    logic [AW-1:0]   ram_a_q, ram_a_d;
    logic [DW-1:0]   ram_d_q, ram_d_d;
    logic            tag1Valid_q, tag1Valid_d;
    logic [PW-1:0]   tag1Idx_q, tag1Idx_d;
    logic            tag2Valid_q;
    logic [PW-1:0]   tag2Idx_q;
    logic            gntAny;
    logic [PW-1:0]   gntIdx;

    function automatic logic [PW-1:0] nextIdx(input logic [PW-1:0] i);
        return (i == PW'(N - 1)) ? '0 : i + 1'b1;
    endfunction

    // A locked owner is the only candidate; otherwise search upward from ptr with wrap.
    always_comb begin
        int cand;
        cand   = 0;
        gntAny = 1'b0;
        gntIdx = '0;
        if (state_q == ST_LOCKED) begin
            gntAny = bus.req[lockOwner_q];
            gntIdx = lockOwner_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N) cand = cand - N;
                if (!gntAny && bus.req[cand]) begin
                    gntAny = 1'b1;
                    gntIdx = PW'(cand);
                end
            end
        end
        if (!rst_n) gntAny = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lockOwner_d = lockOwner_q;
        ram_w_d     = 1'b0;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;
        tag1Valid_d = 1'b0;
        tag1Idx_d   = tag1Idx_q;
        if (gntAny) begin
            ptr_d       = nextIdx(gntIdx);
            ram_w_d     = bus.w[gntIdx];
            ram_a_d     = bus.a[int'(gntIdx)*AW +: AW];
            ram_d_d     = bus.d[int'(gntIdx)*DW +: DW];
            tag1Valid_d = !bus.w[gntIdx];
            tag1Idx_d   = gntIdx;
            lockOwner_d = gntIdx;
            state_d     = bus.lock[gntIdx] ? ST_LOCKED : ST_OPEN;
        end else if (state_q == ST_LOCKED && !bus.lock[lockOwner_q]) begin
            // Owner went idle and let go of the lock without a final access.
            state_d = ST_OPEN;
            ptr_d   = nextIdx(lockOwner_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OPEN;
            ptr_q       <= '0;
            lockOwner_q <= '0;
            ram_w_q     <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= '0;
            tag1Valid_q <= 1'b0;
            tag1Idx_q   <= '0;
            tag2Valid_q <= 1'b0;
            tag2Idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lockOwner_q <= lockOwner_d;
            ram_w_q     <= ram_w_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
            tag1Valid_q <= tag1Valid_d;
            tag1Idx_q   <= tag1Idx_d;
            tag2Valid_q <= tag1Valid_q;
            tag2Idx_q   <= tag1Idx_q;
        end
    end

    always_comb begin
        bus.gnt = '0;
        bus.qv  = '0;
        if (gntAny) bus.gnt[gntIdx] = 1'b1;
        if (tag2Valid_q) bus.qv[tag2Idx_q] = 1'b1;
    end

    assign bus.q     = bus.ram_q;
    assign bus.ram_w = ram_w_q;
    assign bus.ram_a = ram_a_q;
    assign bus.ram_d = ram_d_q;

`ifdef ETH_VLG_RAM_ARB_STATS_EN
    logic [15:0] stallCnt_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) stallCnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[i] && !bus.gnt[i] && stallCnt_q[i] != 16'hFFFF)
                    stallCnt_q[i] <= stallCnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int i = 0; i < N; i++) stall_cnt_o[i*16 +: 16] = stallCnt_q[i];
    end
`endif
endmodule

// File: doc/eth_vlg_ram_arb.md
Name: eth_vlg_ram_arb

Overview:
Round-robin arbiter that shares one single-port RAM (synchronous, 1-cycle read latency, write-first output) between N requesters, e.g. the TCP TX buffer writer and retransmit reader.
- Accepts at most one access per cycle.
- Registers the command toward the RAM.
- Routes read data back to the issuing requester with a valid strobe.
- Supports a per-requester lock for atomic multi-cycle bursts.

Parameters:
N, 2, number of requesters (2..8)
AW, 16, RAM address width
DW, 16, RAM data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
req  in  N  access request per requester
lock  in  N  hold ownership after the current grant while high
w  in  N  write (1) / read (0) per requester
a  in  N*AW  address per requester, requester i at [i*AW +: AW]
d  in  N*DW  write data per requester
gnt  out  N  one-hot accept strobe (combinational)
q  out  DW  read data, broadcast to all requesters
qv  out  N  one-hot read-data valid
ram_w  out  1  RAM write enable
ram_a  out  AW  RAM address
ram_d  out  DW  RAM write data
ram_q  in  DW  RAM read data

Behaviour:
- Reset (rst low, async): ptr=0, owner lock cleared, ram_w=0, ram_a=0, ram_d=0, qv=0, pipeline tags cleared. gnt forced to 0 while rst is low.
- Handshake: access i transfers in the cycle where req[i]&gnt[i]=1. Requester holds w/a/d stable while req=1 and gnt=0. gnt is at most one-hot. gnt[i] never asserts without req[i].
- Arbitration, unlocked:
  - Search starts at requester ptr and proceeds ptr, ptr+1, … modulo N. The first requester with req set is granted.
  - After a grant to i: ptr <= (i+1) mod N.
  - No request: ptr unchanged.
- Lock:
  - If granted requester i has lock[i]=1 in the grant cycle, state LOCKED(i) is entered.
  - While LOCKED(i), only i can be granted, every cycle it requests. Other requests stall.
  - Exit occurs on the first grant with lock[i]=0, or when req[i]=0 and lock[i]=0. That cycle sets ptr <= (i+1) mod N.
  - A lock without a request does not acquire ownership.
- Command pipeline: grant at cycle T registers ram_w/ram_a/ram_d at T+1. With no grant, ram_w=0 and ram_a/ram_d hold their previous values.
- Read return:
  - A read granted at T gives ram_q valid at T+2. q=ram_q, combinational pass-through, and qv[i] is high for exactly one cycle, at T+2.
  - Writes never raise qv.
  - A 2-stage tag pipeline (valid bit + requester index, log2 width) tracks ownership. Back-to-back reads from different requesters return in issue order, one per cycle.
- Throughput: 1 access/cycle sustained. No bubble between owners.
- Reset mid-operation: in-flight reads are dropped with no qv. LOCKED is released.

Optional Feature:
Macro ETH_VLG_RAM_ARB_STATS_EN.
- With the macro: adds output stall_cnt, N*16 bits. The counter for requester i increments each cycle with req[i]=1 and gnt[i]=0, saturates at 0xFFFF, and resets to 0.
- Without the macro: the port and counters are absent. The remaining behaviour is identical.

Test Plan:
- N=2, both req held with reads to 0x0010 (r0) and 0x0020 (r1) from reset -> gnt alternates 01,10,01…; qv alternates, starting 2 cycles after the first grant; q returns each address's preloaded data.
- Req0 writes 0xBEEF to 0x0005 at T, then reads 0x0005 at T+1 -> ram_w=1/ram_a=0x0005 at T+1; qv[0] at T+3 with q=0xBEEF.
- Req0 asserts lock for a 4-access burst while req1 is held -> gnt[0] 4 consecutive cycles, gnt[1] in the cycle after the last unlocked grant.
- N=4, only req2 and req3 active, ptr=0 -> first gnt=0100, then 1000, then 0100.
- Assert rst low one cycle after a read grant -> qv stays 0, gnt=0 during reset, ptr=0 after release.
- With ETH_VLG_RAM_ARB_STATS_EN: req1 blocked 5 cycles by a lock -> stall_cnt[1]=5. Hold the block for 70000 cycles -> 0xFFFF.
